// File: rtl/shift_tx_pkg.sv
// Shared types and the round-robin search used by the shift-out arbiter.
package shift_tx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int RR_MAX = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // First set bit of req searching ptr+1, ptr+2, ... modulo n.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                        input logic [3:0]        ptr,
                                        input int                n);
      rr_pick_t r;
      int       kk;
      r  = '0;
      kk = 0;
      for (int i = 1; i <= RR_MAX; i++) begin
         if (i <= n && !r.found) begin
            kk = (int'(ptr) + i) % n;
            if (req[kk[3:0]]) begin
               r.found = 1'b1;
               r.idx   = kk[3:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_tx_arb_rr.sv
// Combinational round-robin pick: index, found flag and one-hot grant.
module rr_arbiter
   import shift_tx_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic               found_o,
   output logic [ID_W-1:0]    gnt_idx_o,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic [RR_MAX-1:0] req_ext;
   rr_pick_t          pick;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req_i;
      pick                   = rr_pick(req_ext, 4'(ptr_i), NUM_REQ);
   end

   assign found_o   = pick.found;
   assign gnt_idx_o = pick.idx[ID_W-1:0];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign gnt_o[gi] = pick.found && (pick.idx == 4'(gi));
      end
   endgenerate

endmodule

// File: rtl/shift_tx_arb.sv
// Round-robin arbiter sharing one MSB-first shift-out register among NUM_REQ
// word producers; one word is shifted per grant under the external ser_en.
module shift_tx_arb
   import shift_tx_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          ser_en,
   output logic                          ser_out,
   output logic                          ser_valid,
   output logic                          ser_last,
   output logic [ID_W-1:0]               ser_id,
   output logic                          busy
);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] sreg_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [ID_W-1:0]       id_q;
   logic [ID_W-1:0]       rr_ptr_q;

   logic [DATA_WIDTH-1:0] words [NUM_REQ];
   logic                  found;
   logic [ID_W-1:0]       gnt_idx;
   logic [NUM_REQ-1:0]    gnt;
   logic                  in_shift;
   logic                  last_bit;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .found_o   (found),
      .gnt_idx_o (gnt_idx),
      .gnt_o     (gnt)
   );

   assign in_shift = (state_q == SHIFT);
   assign last_bit = in_shift && (cnt_q == CNT_W'(DATA_WIDTH - 1));

   // Grants are only offered from IDLE; reset also silences the accept strobe.
   assign req_ready = (rst && !in_shift) ? gnt : '0;
   assign ser_out   = in_shift & sreg_q[DATA_WIDTH-1];
   assign ser_valid = in_shift;
   assign busy      = in_shift;
   assign ser_last  = last_bit;
   assign ser_id    = in_shift ? id_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         id_q     <= '0;
         rr_ptr_q <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  sreg_q  <= words[gnt_idx];
                  id_q    <= gnt_idx;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (ser_en) begin
                  if (last_bit) begin
                     state_q  <= IDLE;
                     rr_ptr_q <= id_q;
                     sreg_q   <= '0;
                     cnt_q    <= '0;
                  end else begin
                     sreg_q <= sreg_q << 1;
                     cnt_q  <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/shift_tx_arb.md
Name: shift_tx_arb

Overview:
Round-robin arbiter and sequencer that shares one parallel-load, MSB-first shift-out register among NUM_REQ requesters.
- Grants one requester at a time, captures its word into the shift register, and shifts it out serially under an external bit-enable.
- Sits between per-channel word producers and a single serial line driver.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
DATA_WIDTH, 8, bits per word (2..64).
ID_W, derived localparam clog2(NUM_REQ), width of requester index.
CNT_W, derived localparam clog2(DATA_WIDTH), width of bit counter.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  reset; one clock; reset is asynchronous and active-low (deassertion synchronised externally).
req_valid  input  NUM_REQ  per-requester word-available flag.
req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  one-hot grant/accept pulse; word transfers when req_valid[k] and req_ready[k] are both high.
ser_en  input  1  bit-advance enable from the line driver.
ser_out  output  1  current serial bit (shift register MSB).
ser_valid  output  1  high while a word is being shifted.
ser_last  output  1  high while ser_out is the final bit of the word.
ser_id  output  ID_W  index of the requester whose word is on ser_out.
busy  output  1  high in SHIFT state.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; sreg=0; cnt=0; ser_id=0; rr_ptr=NUM_REQ-1, so requester 0 has top priority first. All outputs read 0.
- FSM states: IDLE, SHIFT.
- IDLE, no req_valid: stay; all outputs 0.
- IDLE, any req_valid:
  - Grant g = first k with req_valid[k], searching rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; only one bit is ever high.
  - At the edge: sreg<=req_data[g]; ser_id<=g; cnt<=0; state<=SHIFT.
- SHIFT:
  - ser_valid=1, busy=1, ser_out=sreg[DATA_WIDTH-1], ser_last=(cnt==DATA_WIDTH-1). req_ready all 0.
  - ser_en=1 and not last: sreg<=sreg<<1 (zero fill); cnt<=cnt+1.
  - ser_en=1 and last: state<=IDLE; rr_ptr<=ser_id; sreg cleared.
  - ser_en=0: all state held; arbitrary stall length allowed.
- Latency: first bit appears 1 cycle after the accept cycle. A word occupies exactly DATA_WIDTH ser_en-high cycles. There is a mandatory single IDLE cycle between words; back-to-back throughput is DATA_WIDTH+1 cycles per word when ser_en is held at 1.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 words.
- req_valid deasserting during SHIFT has no effect. A requester is not required to hold its data after its accept cycle.
- ser_en during IDLE is ignored.
- Reset mid-word: word discarded, no ser_last emitted, rr_ptr returns to NUM_REQ-1.
- No combinational path from ser_en to any output. The only combinational paths are req_valid -> req_ready in IDLE.

Decomposition:
- Package shift_tx_pkg: state enum {IDLE, SHIFT}; function rr_pick(req, ptr) returning the grant index and a found flag.
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req and ptr. Instantiated once; the FSM and shift register stay in the top.

Test Plan:
1. Reset release, req_valid=0001, req_data[0]=8'hA5, ser_en=1 -> req_ready=0001 for one cycle; ser_out sequence 1,0,1,0,0,1,0,1; ser_last only on the 8th bit; ser_id=0.
2. req_valid=1111 held, distinct words, ser_en=1 -> grant order 0,1,2,3,0; each word 8 bits with one IDLE gap; 9 cycles per word.
3. Word 8'hF0 with ser_en toggling 1,0,0,1,... -> ser_out and cnt frozen on ser_en=0 cycles; exactly 8 advances before return to IDLE.
4. rst pulled low at bit 4 of 8'h3C from requester 2, then released, req_valid=0101 -> all outputs 0 immediately; first grant after release goes to requester 0, not 2.
5. Only requester 3 requests, followed by requester 3 and requester 1 together -> after serving 3, rr_ptr=3 and the next grant goes to 1 (wrap: search order 0,1,...), confirming round-robin wrap-around.
6. Random traffic over 1000 words (scoreboard) -> every accepted word reproduced bit-exact with correct ser_id; req_ready never multi-hot; no grant while busy.
